// File: rtl/uart_rx_buffered.sv
// 8N1 UART receiver with a first-word-fall-through circular FIFO and a rising-edge read strobe.
// Define UART_RX_PARITY_EN to add an even-parity bit, the PARITY state and the parity_err output.
module uart_rx_buffered #(
  parameter int BUFFER_SIZE  = 16,
  parameter int BIT_PER_WORD = 7,
  parameter int DELAY_FRAMES = 2812
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  uartRx,
  input  logic                  data_clk,
  input  logic                  err_clr,
  output logic [BIT_PER_WORD:0] dataOut,
  output logic                  empty,
  output logic                  full,
  output logic                  overflow,
  output logic                  frame_err,
`ifdef UART_RX_PARITY_EN
  output logic                  parity_err,
`endif
  output logic [2:0]            state_out
);

  localparam int W    = BIT_PER_WORD + 1;
  localparam int PW   = $clog2(BUFFER_SIZE);
  localparam int CW   = $clog2(DELAY_FRAMES + 1);
  localparam int BCW  = $clog2(W);
  localparam int HALF = DELAY_FRAMES / 2;
  localparam logic [CW-1:0]  FULL_LD  = CW'(DELAY_FRAMES - 1);
  localparam logic [CW-1:0]  HALF_LD  = CW'((HALF > 0) ? HALF - 1 : 0);
  localparam logic [BCW-1:0] LAST_BIT = BCW'(BIT_PER_WORD);
  localparam logic [PW:0]    DEPTH    = (PW+1)'(BUFFER_SIZE);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    STOP   = 3'd3,
`ifdef UART_RX_PARITY_EN
    PARITY = 3'd5,
`endif
    STORE  = 3'd4
  } state_t;

  state_t          state, state_nxt;
  logic            rx_meta, rx_sync;
  logic [CW-1:0]   tmr;
  logic            tmr_zero;
  logic [BCW-1:0]  bit_cnt;
  logic [W-1:0]    shreg;
  logic            dclk_q, dclk_prev, pop, push;
  logic            ovf_set, ferr_set;
  logic [PW-1:0]   wr_ptr, rd_ptr;
  logic [PW:0]     count;
  logic [W-1:0]    mem [BUFFER_SIZE];
`ifdef UART_RX_PARITY_EN
  logic            par_bad, perr_set;
`endif

  assign tmr_zero  = (tmr == '0);
  assign empty     = (count == '0);
  assign full      = (count == DEPTH);
  assign pop       = dclk_q && !dclk_prev && !empty;
  assign dataOut   = empty ? '0 : mem[rd_ptr];
  assign state_out = state;

  always_comb begin
    state_nxt = state;
    push      = 1'b0;
    ovf_set   = 1'b0;
    ferr_set  = 1'b0;
`ifdef UART_RX_PARITY_EN
    perr_set  = 1'b0;
`endif
    case (state)
      IDLE:  if (!rx_sync) state_nxt = START;
      START: if (tmr_zero) state_nxt = rx_sync ? IDLE : DATA;
      DATA: begin
        if (tmr_zero && bit_cnt == LAST_BIT) begin
`ifdef UART_RX_PARITY_EN
          state_nxt = PARITY;
`else
          state_nxt = STOP;
`endif
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (tmr_zero) begin
          state_nxt = STOP;
          perr_set  = (rx_sync != ^shreg);
        end
      end
`endif
      STOP: begin
        if (tmr_zero) begin
          ferr_set = !rx_sync;
`ifdef UART_RX_PARITY_EN
          state_nxt = (rx_sync && !par_bad) ? STORE : IDLE;
`else
          state_nxt = rx_sync ? STORE : IDLE;
`endif
        end
      end
      STORE: begin
        state_nxt = IDLE;
        push      = !full || pop;
        ovf_set   = full && !pop;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      rx_meta   <= 1'b1;
      rx_sync   <= 1'b1;
      tmr       <= '0;
      bit_cnt   <= '0;
      shreg     <= '0;
      dclk_q    <= 1'b0;
      dclk_prev <= 1'b0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      overflow  <= 1'b0;
      frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bad    <= 1'b0;
      parity_err <= 1'b0;
`endif
    end else begin
      state     <= state_nxt;
      rx_meta   <= uartRx;
      rx_sync   <= rx_meta;
      dclk_q    <= data_clk;
      dclk_prev <= dclk_q;
      // Reload on every state change and on terminal count, so each state times its own interval.
      if (tmr_zero || state_nxt != state)
        tmr <= (state_nxt == START) ? HALF_LD : FULL_LD;
      else
        tmr <= tmr - 1'b1;
      if (state == IDLE) bit_cnt <= '0;
      if (state == DATA && tmr_zero) begin
        shreg   <= {rx_sync, shreg[W-1:1]};
        bit_cnt <= bit_cnt + 1'b1;
      end
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
      if (err_clr)      overflow <= 1'b0;
      else if (ovf_set) overflow <= 1'b1;
      if (err_clr)       frame_err <= 1'b0;
      else if (ferr_set) frame_err <= 1'b1;
`ifdef UART_RX_PARITY_EN
      if (state == IDLE)  par_bad <= 1'b0;
      else if (perr_set)  par_bad <= 1'b1;
      if (err_clr)       parity_err <= 1'b0;
      else if (perr_set) parity_err <= 1'b1;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= shreg;
  end

endmodule

// File: tb/tb_uart_rx_buffered.sv
// Directed bench for uart_rx_buffered with a queue scoreboard of expected FIFO contents.
module tb_uart_rx_buffered;

  localparam int DF = 16;
  localparam int BS = 16;

  logic       clk = 1'b0;
  logic       rst_n, uart_line, data_clk, err_clr;
  logic [7:0] data_out;
  logic       empty, full, overflow, frame_err;
  logic [2:0] state_out;
`ifdef UART_RX_PARITY_EN
  logic       parity_err;
`endif

  int         checks = 0;
  int         errors = 0;
  logic [7:0] sb_q[$];
  int         occ = 0;
  logic       exp_ovf = 1'b0;

  uart_rx_buffered #(.BUFFER_SIZE(BS), .BIT_PER_WORD(7), .DELAY_FRAMES(DF)) dut (
    .clk(clk), .rst_n(rst_n), .uartRx(uart_line), .data_clk(data_clk), .err_clr(err_clr),
    .dataOut(data_out), .empty(empty), .full(full), .overflow(overflow),
    .frame_err(frame_err),
`ifdef UART_RX_PARITY_EN
    .parity_err(parity_err),
`endif
    .state_out(state_out)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send_bit(input logic v);
    uart_line = v;
    tick(DF);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_ok, input logic par_ok);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
`ifdef UART_RX_PARITY_EN
    send_bit(par_ok ? ^b : ~^b);
`endif
    send_bit(stop_ok);
    uart_line = 1'b1;
    if (!stop_ok || !par_ok) tick(2*DF);
  endtask

  task automatic expect_push(input logic [7:0] b);
    if (occ < BS) begin
      sb_q.push_back(b);
      occ++;
    end else begin
      exp_ovf = 1'b1;
    end
  endtask

  task automatic pop_check(input string tag);
    logic [7:0] exp_w;
    if (sb_q.size() == 0) begin
      check({tag, "_sb_empty"}, 32'd1, 32'd0);
    end else begin
      exp_w = sb_q.pop_front();
      occ--;
      check(tag, {24'd0, data_out}, {24'd0, exp_w});
    end
    data_clk = 1'b1;
    tick(2);
    data_clk = 1'b0;
    tick(2);
  endtask

  initial begin
    rst_n = 1'b0; uart_line = 1'b1; data_clk = 1'b0; err_clr = 1'b0;
    tick(3);
    check("rst_state", {29'd0, state_out}, 32'd0);
    check("rst_empty", {31'd0, empty}, 32'd1);
    check("rst_full", {31'd0, full}, 32'd0);
    check("rst_ovf", {31'd0, overflow}, 32'd0);
    check("rst_ferr", {31'd0, frame_err}, 32'd0);
    check("rst_data", {24'd0, data_out}, 32'd0);
    rst_n = 1'b1;
    tick(4);

    // single word, then pop
    send_byte(8'h55, 1'b1, 1'b1);
    expect_push(8'h55);
    tick(4);
    check("w55_empty", {31'd0, empty}, 32'd0);
    check("w55_ferr", {31'd0, frame_err}, 32'd0);
    pop_check("w55_data");
    check("w55_empty_after_pop", {31'd0, empty}, 32'd1);

    // read strobe on an empty FIFO must not underflow
    data_clk = 1'b1; tick(2); data_clk = 1'b0; tick(2);
    check("underflow_empty", {31'd0, empty}, 32'd1);

    // short low glitch
    uart_line = 1'b0; tick(3); uart_line = 1'b1;
    tick(DF + 4);
    check("glitch_state", {29'd0, state_out}, 32'd0);
    check("glitch_empty", {31'd0, empty}, 32'd1);

    // bad stop bit
    send_byte(8'hA3, 1'b0, 1'b1);
    check("ferr_set", {31'd0, frame_err}, 32'd1);
    check("ferr_empty", {31'd0, empty}, 32'd1);
    err_clr = 1'b1; tick(1); err_clr = 1'b0;
    check("ferr_clr", {31'd0, frame_err}, 32'd0);

    // 17 back-to-back words into a 16-deep FIFO
    for (int i = 0; i < 17; i++) begin
      send_byte(8'(i), 1'b1, 1'b1);
      expect_push(8'(i));
      if (i == 14) check("full_at_15", {31'd0, full}, 32'd0);
      if (i == 15) check("full_at_16", {31'd0, full}, 32'd1);
    end
    tick(4);
    check("ovf_set", {31'd0, overflow}, {31'd0, exp_ovf});
    check("full_after_17", {31'd0, full}, 32'd1);
    err_clr = 1'b1; tick(1); err_clr = 1'b0; exp_ovf = 1'b0;
    check("ovf_clr", {31'd0, overflow}, 32'd0);
    for (int i = 0; i < 16; i++) pop_check("wrap_read");
    check("wrap_empty", {31'd0, empty}, 32'd1);

    // refill, then pop in the same cycle as STORE while full
    for (int i = 0; i < 16; i++) begin
      send_byte(8'h80 + 8'(i), 1'b1, 1'b1);
      expect_push(8'h80 + 8'(i));
    end
    tick(2);
    check("refill_full", {31'd0, full}, 32'd1);
    fork
      send_byte(8'hAA, 1'b1, 1'b1);
      begin
        int n;
        n = 0;
        while (state_out != 3'd3 && n < 400) begin
          @(negedge clk);
          n++;
        end
        check("stop_seen", {31'd0, (n < 400)}, 32'd1);
        repeat (DF - 1) @(posedge clk);
        #1;
        check("sim_head", {24'd0, data_out}, {24'd0, sb_q.pop_front()});
        sb_q.push_back(8'hAA);
        data_clk = 1'b1;
        tick(3);
        data_clk = 1'b0;
      end
    join
    tick(4);
    check("sim_ovf", {31'd0, overflow}, 32'd0);
    check("sim_full", {31'd0, full}, 32'd1);
    for (int i = 0; i < 16; i++) pop_check("sim_read");
    check("sim_empty", {31'd0, empty}, 32'd1);

    // reset mid-DATA aborts the frame
    uart_line = 1'b0;
    tick(DF * 4);
    rst_n = 1'b0;
    uart_line = 1'b1;
    tick(2);
    check("midrst_state", {29'd0, state_out}, 32'd0);
    rst_n = 1'b1;
    tick(4);
    check("midrst_empty", {31'd0, empty}, 32'd1);
    send_byte(8'h3C, 1'b1, 1'b1);
    expect_push(8'h3C);
    tick(4);
    check("w3c_empty", {31'd0, empty}, 32'd0);
    pop_check("w3c_data");
    check("w3c_only", {31'd0, empty}, 32'd1);

`ifdef UART_RX_PARITY_EN
    send_byte(8'h3C, 1'b1, 1'b0);
    check("perr_set", {31'd0, parity_err}, 32'd1);
    check("perr_empty", {31'd0, empty}, 32'd1);
    err_clr = 1'b1; tick(1); err_clr = 1'b0;
    check("perr_clr", {31'd0, parity_err}, 32'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_rx_buffered.md
# uart_rx_buffered

Receive-side counterpart of the buffered UART transmitter: deserialises 8N1 frames from the `uartRx` pin, buffers completed words in an internal circular FIFO, and presents them to the consumer through a rising-edge read strobe. It sits between the board RX pin and user logic. It mirrors the transmit path's word width, baud divider and buffer depth, so one parameter set configures both directions of a link.

## Interface
- `BUFFER_SIZE`, default 16: FIFO depth in words; power of two, at least 2.
- `BIT_PER_WORD`, default 7: MSB index of a word; word width is `BIT_PER_WORD+1`.
- `DELAY_FRAMES`, default 2812: clock cycles per bit (27 MHz / 9600 baud).
- `clk`  in  1: sole clock, rising edge.
- `rst_n`  in  1: asynchronous, active-low reset.
- `uartRx`  in  1: serial line; idle high; asynchronous to `clk`.
- `data_clk`  in  1: read strobe; each rising edge pops one word.
- `err_clr`  in  1: level input; while high, clears the sticky error flags.
- `dataOut`  out  `BIT_PER_WORD+1`: FIFO head word; valid only while `empty`=0.
- `empty`  out  1: FIFO holds no words.
- `full`  out  1: FIFO holds `BUFFER_SIZE` words.
- `overflow`  out  1: sticky; a received word was dropped because the FIFO was full.
- `frame_err`  out  1: sticky; a stop bit was sampled low.
- `state_out`  out  3: current receiver state encoding.

## Operation
- `uartRx` passes through a 2-FF synchroniser; both stages reset to 1.
- Receiver states:
  - IDLE=0: on synchronised line =0, clear the bit counter and go to START.
  - START=1: wait `DELAY_FRAMES/2` cycles (floor). If the line is still 0, go to DATA; otherwise treat it as a glitch and return to IDLE.
  - DATA=2: every `DELAY_FRAMES` cycles, sample one bit, LSB first. After `BIT_PER_WORD+1` bits, go to STOP.
  - STOP=3: wait `DELAY_FRAMES` cycles and sample. If the sample is 1, go to STORE. If it is 0, set `frame_err`, discard the word, and go to IDLE.
  - STORE=4: one cycle. Push the word into the FIFO if it is not full; otherwise drop it and set `overflow`. Then go to IDLE.
- Read side:
  - `data_clk` is registered once; a rising edge is detected as current=1 and previous=0.
  - A detected edge pops the head word when `empty`=0. A detected edge while empty is ignored and does not underflow.
  - `dataOut` is first-word fall-through and shows the head word combinationally from the FIFO.
- FIFO: read and write pointers are `$clog2(BUFFER_SIZE)` bits and wrap modulo `BUFFER_SIZE`. An occupancy counter with range 0..`BUFFER_SIZE` drives `full` and `empty`.
- A push and a pop in the same cycle both occur and leave occupancy unchanged. When `full`=1, a simultaneous push and pop succeeds and sets no overflow.
- The sticky flags `overflow` and `frame_err` clear only on `rst_n` low or `err_clr` high. `err_clr` has priority over a same-cycle set.

## Timing
- Reset values:
  - `state_out`=0; `empty`=1; `full`=0; `overflow`=0; `frame_err`=0; `dataOut`=0.
  - Pointers, counters and the edge register are 0; the synchroniser is 1.
- Reset asserted mid-frame aborts the frame immediately; no partial word is pushed.
- Start bit is sampled `DELAY_FRAMES/2` cycles after the falling edge is seen at the synchroniser output, which is 2 cycles after the pin edge.
- Data bit n is sampled `DELAY_FRAMES*(n+1)` cycles after the start-bit sample. The stop bit is sampled `DELAY_FRAMES` cycles after the last data bit.
- STORE follows the stop-bit sample by 1 cycle. `empty` falls and `dataOut` updates 1 cycle after STORE.
- Pop latency: `data_clk` rises at cycle t; the pointer advances at the edge ending cycle t+1; the new head appears at t+2.
- The receiver re-arms in IDLE one cycle after STORE. It therefore accepts back-to-back frames with a single stop bit.

## Configuration
- `UART_RX_PARITY_EN` defined:
  - Adds state PARITY=5 between DATA and STOP. It samples one even-parity bit `DELAY_FRAMES` cycles after the last data bit.
  - Adds output port `parity_err` (1 bit, sticky, reset 0, cleared by `err_clr`).
  - On a parity mismatch the word is discarded and `parity_err` is set. The stop bit is still checked.
- Undefined: no PARITY state and no `parity_err` port; the frame is 8N1.

## Test plan
- `DELAY_FRAMES`=16: send 0x55 with a valid stop bit -> `empty` falls; `dataOut`=0x55; `frame_err`=0; one `data_clk` pulse -> `empty`=1.
- Drive a 3-cycle low glitch on `uartRx` -> `state_out` returns to 0 and no word is pushed.
- Send 0xA3 with the stop bit low -> `frame_err`=1 and `empty` stays 1. Pulse `err_clr` -> `frame_err`=0.
- Send 17 words 0x00..0x10 with no reads -> `full`=1 after word 16 and `overflow`=1. Reading 16 times returns 0x00..0x0F in order and exercises pointer wrap.
- Time a `data_clk` edge so the pop lands in the same cycle as STORE while the FIFO is full -> both operations succeed, `overflow` stays 0, occupancy stays 16.
- Assert `rst_n` low mid-DATA, release it, then send 0x3C -> only 0x3C is received. With `UART_RX_PARITY_EN` defined, send 0x3C with odd parity -> `parity_err`=1 and no word is pushed.
